data_island_scheduler: RTL

Schedules HDMI data islands inside horizontal blanking and feeds the packet assembler stage. It watches the pixel X coordinate, pulls queued packets from a packet source over a valid/ready handshake, and sequences each island:

- preamble
- leading guard band
- one or more 32-cycle packet slots
- trailing guard band

It drives `data_island_period`, the 5-bit slot `counter`, and the latched header/subpacket words consumed downstream, plus preamble/guard flags for the TMDS channel muxing.

---
 rtl/hdmi_pkg.sv | 8 +
 rtl/data_island_scheduler_if.sv | 12 +
 rtl/data_island_scheduler.sv | 114 +++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared data island state encoding, timing lengths and subpacket type
package hdmi_pkg;
  typedef enum logic [2:0] {IDLE, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD} di_state_t;
  localparam int DI_PREAMBLE_LEN = 8;
  localparam int DI_GUARD_LEN = 2;
  localparam int DI_PACKET_LEN = 32;
  typedef logic [3:0][55:0] subpacket_t;
endpackage

// File: rtl/data_island_scheduler_if.sv
// data_island_scheduler_if: packet source handshake (valid/ready, 24-bit header, 4x56 subpackets)
//   master: packet source drives pkt_valid/pkt_header/pkt_sub, receives pkt_ready
//   slave:  scheduler samples the packet, drives the one-cycle pkt_ready accept strobe
interface data_island_scheduler_if;
  import hdmi_pkg::*;
  logic pkt_valid;
  logic [23:0] pkt_header;
  subpacket_t pkt_sub;
  logic pkt_ready;
  modport master(output pkt_valid, pkt_header, pkt_sub, input pkt_ready);
  modport slave(input pkt_valid, pkt_header, pkt_sub, output pkt_ready);
endinterface

// File: rtl/data_island_scheduler.sv
// data_island_scheduler: places HDMI data islands (preamble, guard, 32-cycle packets, guard) in horizontal blanking
//   clk_pixel/rst_n: pixel clock, synchronous active-low reset
//   cx: pixel X; pkt: packet source handshake (slave side)
//   data_island_period/counter/header/sub: packet slot, slot position and latched packet for the assembler
//   di_preamble/di_guard: TMDS channel mux flags
module data_island_scheduler
  import hdmi_pkg::*;
#(
  parameter int BIT_WIDTH = 10,
  parameter int SCREEN_WIDTH = 640,
  parameter int FRAME_WIDTH = 800,
  parameter int CTRL_MIN = 4,
  parameter int VIDEO_RESERVE = 22,
  parameter int MAX_PACKETS = 18
) (
  input  logic                  clk_pixel,
  input  logic                  rst_n,
  input  logic [BIT_WIDTH-1:0]  cx,
  data_island_scheduler_if.slave pkt,
  output logic                  data_island_period,
  output logic [4:0]            counter,
  output logic [23:0]           header,
  output subpacket_t            sub,
  output logic                  di_preamble,
  output logic                  di_guard
);
  localparam int DI_START = SCREEN_WIDTH + CTRL_MIN;
  localparam int LIMIT = FRAME_WIDTH - 1 - VIDEO_RESERVE;
  localparam int NW = $clog2(MAX_PACKETS + 1);
  localparam logic [4:0] LAST = 5'(DI_PACKET_LEN - 1);
  di_state_t state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [4:0] counter_q, counter_d;
  logic [NW-1:0] pkt_num_q, pkt_num_d;
  logic line_done_q, line_done_d;
  logic ready_q, ready_d;
  logic [23:0] header_q;
  subpacket_t sub_q;
  logic dip_q, pre_q, guard_q;
  logic room;
  // ready is registered, so the continue decision is taken one cycle early (counter 30, cx one less)
  assign room = 32'(cx) + 32'd35 <= 32'(LIMIT);
  always_comb begin
    state_d = state_q;
    phase_d = phase_q - 3'd1;
    counter_d = counter_q;
    pkt_num_d = ready_q ? pkt_num_q + NW'(1) : pkt_num_q;
    line_done_d = line_done_q && cx != '0;
    case (state_q)
      IDLE: if (cx == BIT_WIDTH'(DI_START) && pkt.pkt_valid && !line_done_q) begin
        state_d = PREAMBLE;
        phase_d = 3'(DI_PREAMBLE_LEN - 1);
        pkt_num_d = '0;
        line_done_d = 1'b1;
      end
      PREAMBLE: if (phase_q == '0) begin
        state_d = LEAD_GUARD;
        phase_d = 3'(DI_GUARD_LEN - 1);
      end
      LEAD_GUARD: if (phase_q == '0) begin
        state_d = ready_q ? PACKET : TRAIL_GUARD;
        phase_d = 3'(DI_GUARD_LEN - 1);
        counter_d = '0;
      end
      PACKET: begin
        counter_d = counter_q + 5'd1;
        if (counter_q == LAST && !ready_q) begin
          state_d = TRAIL_GUARD;
          phase_d = 3'(DI_GUARD_LEN - 1);
        end
      end
      TRAIL_GUARD: if (phase_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // an unexpected line wrap abandons the island
    if (cx == '0 && state_q != IDLE) state_d = IDLE;
    ready_d = pkt.pkt_valid && ((state_d == LEAD_GUARD && phase_d == '0) ||
              (state_d == PACKET && counter_d == LAST && pkt_num_d < NW'(MAX_PACKETS) && room));
  end
  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      counter_q <= '0;
      pkt_num_q <= '0;
      line_done_q <= 1'b0;
      ready_q <= 1'b0;
      header_q <= '0;
      sub_q <= '0;
      dip_q <= 1'b0;
      pre_q <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      counter_q <= counter_d;
      pkt_num_q <= pkt_num_d;
      line_done_q <= line_done_d;
      ready_q <= ready_d;
      header_q <= ready_q ? pkt.pkt_header : header_q;
      sub_q <= ready_q ? pkt.pkt_sub : sub_q;
      dip_q <= state_d == PACKET;
      pre_q <= state_d == PREAMBLE;
      guard_q <= state_d == LEAD_GUARD || state_d == TRAIL_GUARD;
    end
  end
  assign pkt.pkt_ready = ready_q;
  assign data_island_period = dip_q;
  assign counter = counter_q;
  assign header = header_q;
  assign sub = sub_q;
  assign di_preamble = pre_q;
  assign di_guard = guard_q;
endmodule
